// File: rtl/rv_decode_pkg.sv
// Shared RV32I decode definitions: instruction ids, major opcodes and immediate formats.
// Imported by the decode stage and its immediate generator.
package rv_decode_pkg;

    localparam logic [5:0] ID_LUI    = 6'd0,  ID_AUIPC  = 6'd1,  ID_JAL    = 6'd2,  ID_JALR   = 6'd3;
    localparam logic [5:0] ID_BEQ    = 6'd4,  ID_BNE    = 6'd5,  ID_BLT    = 6'd6,  ID_BGE    = 6'd7;
    localparam logic [5:0] ID_BLTU   = 6'd8,  ID_BGEU   = 6'd9,  ID_LB     = 6'd10, ID_LH     = 6'd11;
    localparam logic [5:0] ID_LW     = 6'd12, ID_LBU    = 6'd13, ID_LHU    = 6'd14, ID_SB     = 6'd15;
    localparam logic [5:0] ID_SH     = 6'd16, ID_SW     = 6'd17, ID_ADDI   = 6'd18, ID_SLTI   = 6'd19;
    localparam logic [5:0] ID_SLTIU  = 6'd20, ID_XORI   = 6'd21, ID_ORI    = 6'd22, ID_ANDI   = 6'd23;
    localparam logic [5:0] ID_SLLI   = 6'd24, ID_SRLI   = 6'd25, ID_SRAI   = 6'd26, ID_ADD    = 6'd27;
    localparam logic [5:0] ID_SUB    = 6'd28, ID_SLL    = 6'd29, ID_SLT    = 6'd30, ID_SLTU   = 6'd31;
    localparam logic [5:0] ID_XOR    = 6'd32, ID_SRL    = 6'd33, ID_SRA    = 6'd34, ID_OR     = 6'd35;
    localparam logic [5:0] ID_AND    = 6'd36, ID_FENCE  = 6'd37, ID_FENCE_I = 6'd38, ID_ECALL = 6'd39;
    localparam logic [5:0] ID_EBREAK = 6'd40, ID_CSRRW  = 6'd41, ID_CSRRS  = 6'd42, ID_CSRRC  = 6'd43;
    localparam logic [5:0] ID_CSRRWI = 6'd44, ID_CSRRSI = 6'd45, ID_CSRRCI = 6'd46;
    // Fence ids are reserved for the memory-ordering unit; this stage flags them illegal.
    localparam logic [5:0] ILLEGAL_ID = 6'h3F;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_ALUI   = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_ALU    = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5
    } imm_fmt_e;

endpackage

// File: rtl/rv_decode_stage_imm_gen.sv
// Combinational RV32I immediate assembly, sign-extended to XLEN.
module rv_imm_gen
    import rv_decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:7]     instr,
    input  logic [2:0]      fmt,
    output logic [XLEN-1:0] imm
);

    logic signed [31:0] imm32_s;

    // Assemble the 32-bit immediate for the selected format
    always_comb begin
        imm32_s = 32'sd0;
        case (imm_fmt_e'(fmt))
            FMT_I:   imm32_s = {{20{instr[31]}}, instr[31:20]};
            FMT_S:   imm32_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B:   imm32_s = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            FMT_U:   imm32_s = {instr[31:12], 12'b0};
            FMT_J:   imm32_s = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm32_s = 32'sd0;
        endcase
    end

    assign imm = XLEN'(imm32_s);

endmodule

// File: rtl/rv_decode_stage.sv
// RV32I decode stage: classifies each fetched word on entry and holds results
// in a small head-ordered output queue with flush support.
module rv_decode_stage
    import rv_decode_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int ID_W  = 6,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [4:0]      rd,
    output logic [2:0]      func3,
    output logic [6:0]      func7,
    output logic [XLEN-1:0] imm,
    output logic [ID_W-1:0] instr_id,
    output logic            illegal
);

    localparam int E_W = XLEN + 25 + XLEN + ID_W + 1;
    localparam logic [1:0] DEPTH_C = 2'(DEPTH);
    localparam logic [E_W-1:0] RST_ENTRY = {{(E_W-ID_W-1){1'b0}}, {ID_W{1'b1}}, 1'b0};

    logic [1:0]      count_r;
    logic [1:0]      count_next_s;
    logic            in_ready_r;
    logic [E_W-1:0]  slot0_r;
    logic [E_W-1:0]  slot1_r;
    logic [E_W-1:0]  new_entry_s;
    logic [31:7]     head_instr_s;
    logic [5:0]      id_s;
    imm_fmt_e        fmt_s;
    logic            illegal_s;
    logic [XLEN-1:0] imm_raw_s;
    logic            push_s;
    logic            pop_s;
    logic [6:0]      opcode_s;
    logic [2:0]      f3_s;
    logic [6:0]      f7_s;

    assign opcode_s = in_instr[6:0];
    assign f3_s     = in_instr[14:12];
    assign f7_s     = in_instr[31:25];

    // Classify the incoming word into an instruction id and immediate format
    always_comb begin
        id_s  = ILLEGAL_ID;
        fmt_s = FMT_NONE;
        case (opcode_s)
            OP_LUI:   begin id_s = ID_LUI;   fmt_s = FMT_U; end
            OP_AUIPC: begin id_s = ID_AUIPC; fmt_s = FMT_U; end
            OP_JAL:   begin id_s = ID_JAL;   fmt_s = FMT_J; end
            OP_JALR:  begin id_s = (f3_s == 3'b000) ? ID_JALR : ILLEGAL_ID; fmt_s = FMT_I; end
            OP_BRANCH: begin
                fmt_s = FMT_B;
                case (f3_s)
                    3'b000:  id_s = ID_BEQ;
                    3'b001:  id_s = ID_BNE;
                    3'b100:  id_s = ID_BLT;
                    3'b101:  id_s = ID_BGE;
                    3'b110:  id_s = ID_BLTU;
                    3'b111:  id_s = ID_BGEU;
                    default: id_s = ILLEGAL_ID;
                endcase
            end
            OP_LOAD: begin
                fmt_s = FMT_I;
                case (f3_s)
                    3'b000:  id_s = ID_LB;
                    3'b001:  id_s = ID_LH;
                    3'b010:  id_s = ID_LW;
                    3'b100:  id_s = ID_LBU;
                    3'b101:  id_s = ID_LHU;
                    default: id_s = ILLEGAL_ID;
                endcase
            end
            OP_STORE: begin
                fmt_s = FMT_S;
                case (f3_s)
                    3'b000:  id_s = ID_SB;
                    3'b001:  id_s = ID_SH;
                    3'b010:  id_s = ID_SW;
                    default: id_s = ILLEGAL_ID;
                endcase
            end
            OP_ALUI: begin
                fmt_s = FMT_I;
                case (f3_s)
                    3'b000:  id_s = ID_ADDI;
                    3'b010:  id_s = ID_SLTI;
                    3'b011:  id_s = ID_SLTIU;
                    3'b100:  id_s = ID_XORI;
                    3'b110:  id_s = ID_ORI;
                    3'b111:  id_s = ID_ANDI;
                    3'b001:  id_s = (f7_s == F7_ZERO) ? ID_SLLI : ILLEGAL_ID;
                    3'b101:  id_s = (f7_s == F7_ZERO) ? ID_SRLI : (f7_s == F7_ALT) ? ID_SRAI : ILLEGAL_ID;
                    default: id_s = ILLEGAL_ID;
                endcase
            end
            OP_ALU: begin
                fmt_s = FMT_NONE;
                case (f3_s)
                    3'b000:  id_s = (f7_s == F7_ZERO) ? ID_ADD : (f7_s == F7_ALT) ? ID_SUB : ILLEGAL_ID;
                    3'b101:  id_s = (f7_s == F7_ZERO) ? ID_SRL : (f7_s == F7_ALT) ? ID_SRA : ILLEGAL_ID;
                    3'b001:  id_s = (f7_s == F7_ZERO) ? ID_SLL  : ILLEGAL_ID;
                    3'b010:  id_s = (f7_s == F7_ZERO) ? ID_SLT  : ILLEGAL_ID;
                    3'b011:  id_s = (f7_s == F7_ZERO) ? ID_SLTU : ILLEGAL_ID;
                    3'b100:  id_s = (f7_s == F7_ZERO) ? ID_XOR  : ILLEGAL_ID;
                    3'b110:  id_s = (f7_s == F7_ZERO) ? ID_OR   : ILLEGAL_ID;
                    3'b111:  id_s = (f7_s == F7_ZERO) ? ID_AND  : ILLEGAL_ID;
                    default: id_s = ILLEGAL_ID;
                endcase
            end
            OP_SYSTEM: begin
                fmt_s = FMT_NONE;
                if (in_instr == 32'h0000_0073) begin
                    id_s = ID_ECALL;
                end else if (in_instr == 32'h0010_0073) begin
                    id_s = ID_EBREAK;
                end else begin
                    case (f3_s)
                        3'b001:  id_s = ID_CSRRW;
                        3'b010:  id_s = ID_CSRRS;
                        3'b011:  id_s = ID_CSRRC;
                        3'b101:  id_s = ID_CSRRWI;
                        3'b110:  id_s = ID_CSRRSI;
                        3'b111:  id_s = ID_CSRRCI;
                        default: id_s = ILLEGAL_ID;
                    endcase
                end
            end
            default: begin id_s = ILLEGAL_ID; fmt_s = FMT_NONE; end
        endcase
    end

    assign illegal_s = (id_s == ILLEGAL_ID);

    rv_imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .instr (in_instr[31:7]),
        .fmt   (fmt_s),
        .imm   (imm_raw_s)
    );

    // Illegal words keep their fields but carry a zero immediate and the all-ones id
    assign new_entry_s = {in_pc, in_instr[31:7],
                          illegal_s ? {XLEN{1'b0}} : imm_raw_s,
                          illegal_s ? {ID_W{1'b1}} : ID_W'(id_s),
                          illegal_s};

    assign out_valid = (count_r != 2'd0);
    assign in_ready  = in_ready_r;
    assign push_s    = in_valid & in_ready_r & ~flush;
    assign pop_s     = out_valid & out_ready;

    // Next occupancy from the push/pop handshakes
    always_comb begin
        count_next_s = count_r;
        if (flush) begin
            count_next_s = 2'd0;
        end else if (push_s && !pop_s) begin
            count_next_s = count_r + 2'd1;
        end else if (pop_s && !push_s) begin
            count_next_s = count_r - 2'd1;
        end else begin
            count_next_s = count_r;
        end
    end

    // Queue storage; slot0 is always the head entry
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r    <= 2'd0;
            in_ready_r <= 1'b0;
            slot0_r    <= RST_ENTRY;
            slot1_r    <= RST_ENTRY;
        end else begin
            count_r    <= count_next_s;
            in_ready_r <= (count_next_s < DEPTH_C);
            if (!flush) begin
                if (push_s && (count_r == 2'd0 || pop_s)) begin
                    slot0_r <= new_entry_s;
                end else if (pop_s && count_r == 2'd2) begin
                    slot0_r <= slot1_r;
                end
                if (push_s && count_r == 2'd1 && !pop_s) begin
                    slot1_r <= new_entry_s;
                end
            end
        end
    end

    assign {out_pc, head_instr_s, imm, instr_id, illegal} = slot0_r;
    assign rd    = head_instr_s[11:7];
    assign func3 = head_instr_s[14:12];
    assign rs1   = head_instr_s[19:15];
    assign rs2   = head_instr_s[24:20];
    assign func7 = head_instr_s[31:25];

endmodule
